branch_predict_resolver: RTL

//  Parametrised branch unit: replaces combinational-only resolution with predict-at-fetch plus resolve-at-EX.
//  IF stage: looks up a BHT (2-bit saturating counters) and a direct-mapped BTB to predict next PC.
//  EX stage: resolves br/jal/jalr, trains the tables and issues a registered one-cycle redirect on mispredict.

---
 rtl/branch_predict_resolver.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/branch_predict_resolver.sv
// Branch predict/resolve unit: BHT + direct-mapped BTB lookup at fetch,
// resolution, table training and a registered one-cycle redirect at EX,
// plus 32-bit counters of resolved and mispredicted control-flow instructions.

package rv32i_types;
    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;
endpackage

package pcmux;
    typedef enum logic [1:0] {
        pc_plus4 = 2'b00,
        alu_out  = 2'b01,
        alu_mod2 = 2'b10
    } pcmux_sel_t;
endpackage

module branch_predict_resolver
    import rv32i_types::*;
    import pcmux::*;
#(
    parameter int width     = 32,
    parameter int BHT_DEPTH = 64,
    parameter int BTB_DEPTH = 16,
    parameter int CTR_BITS  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] if_pc_i,
    output logic             if_pred_taken_o,
    output logic [width-1:0] if_pred_target_o,
    input  logic             ex_valid_i,
    input  rv32i_opcode      ex_opcode_i,
    input  logic [width-1:0] ex_pc_i,
    input  logic             ex_pred_taken_i,
    input  logic [width-1:0] ex_pred_target_i,
    input  logic [width-1:0] i_imm_i,
    input  logic [width-1:0] b_imm_i,
    input  logic [width-1:0] j_imm_i,
    input  logic [width-1:0] rs1_out_i,
    input  logic             br_en_i,
    input  logic             stall_i,
    output logic             redirect_o,
    output logic [width-1:0] addr_o,
    output pcmux_sel_t       pcmux_sel_o,
    output logic [31:0]      branch_cnt_o,
    output logic [31:0]      mispredict_cnt_o
);

    localparam int BHT_IDX = $clog2(BHT_DEPTH);
    localparam int BTB_IDX = $clog2(BTB_DEPTH);
    localparam int TAG_W   = width - BTB_IDX - 2;

    // Weakly-not-taken is MSB clear with all lower bits set
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;
    localparam logic [width-1:0]    FOUR     = width'(4);
    localparam logic [width-1:0]    LSB_MASK = ~width'(1);

    logic [CTR_BITS-1:0] bht        [BHT_DEPTH];
    logic                btb_valid  [BTB_DEPTH];
    logic [TAG_W-1:0]    btb_tag    [BTB_DEPTH];
    logic [width-1:0]    btb_target [BTB_DEPTH];
    logic                btb_jal    [BTB_DEPTH];

    logic [BHT_IDX-1:0] if_bi;
    logic [BTB_IDX-1:0] if_ti;
    logic [TAG_W-1:0]   if_tag;
    logic               if_hit;

    logic [BHT_IDX-1:0] ex_bi;
    logic [BTB_IDX-1:0] ex_ti;
    logic [TAG_W-1:0]   ex_tag;

    logic               is_br;
    logic               is_jal;
    logic               is_jalr;
    logic               is_cf;
    logic               res;
    logic               train;
    logic               act_taken;
    logic [width-1:0]   act_tgt;
    logic               mispred;

    assign if_bi  = if_pc_i[BHT_IDX+1:2];
    assign if_ti  = if_pc_i[BTB_IDX+1:2];
    assign if_tag = if_pc_i[width-1:BTB_IDX+2];

    assign ex_bi  = ex_pc_i[BHT_IDX+1:2];
    assign ex_ti  = ex_pc_i[BTB_IDX+1:2];
    assign ex_tag = ex_pc_i[width-1:BTB_IDX+2];

    // Fetch-side prediction from pre-edge table contents
    always_comb begin
        if_hit           = btb_valid[if_ti] && (btb_tag[if_ti] == if_tag);
        if_pred_taken_o  = if_hit && (btb_jal[if_ti] || bht[if_bi][CTR_BITS-1]);
        if_pred_target_o = if_pred_taken_o ? btb_target[if_ti] : (if_pc_i + FOUR);
    end

    // EX-side resolution of the actual outcome and mispredict detection
    always_comb begin
        is_br     = (ex_opcode_i == op_br);
        is_jal    = (ex_opcode_i == op_jal);
        is_jalr   = (ex_opcode_i == op_jalr);
        is_cf     = is_br || is_jal || is_jalr;
        act_taken = br_en_i;
        act_tgt   = ex_pc_i + b_imm_i;
        if (is_jal) begin
            act_taken = 1'b1;
            act_tgt   = ex_pc_i + j_imm_i;
        end else if (is_jalr) begin
            act_taken = 1'b1;
            act_tgt   = (rs1_out_i + i_imm_i) & LSB_MASK;
        end
        mispred = (act_taken != ex_pred_taken_i) ||
                  (act_taken && (act_tgt != ex_pred_target_i));
    end

    // The instruction in EX during a redirect is wrong-path and is ignored
    assign res   = ex_valid_i && !stall_i && !redirect_o;
    assign train = res && is_cf;

    // Train BHT counters on branches and record taken br/jal targets in the BTB
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= CTR_INIT;
            end
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_jal[i]    <= 1'b0;
            end
        end else if (train) begin
            if (is_br) begin
                if (act_taken && (bht[ex_bi] != CTR_MAX)) begin
                    bht[ex_bi] <= bht[ex_bi] + 1'b1;
                end else if (!act_taken && (bht[ex_bi] != '0)) begin
                    bht[ex_bi] <= bht[ex_bi] - 1'b1;
                end
            end
            if (act_taken && !is_jalr) begin
                btb_valid[ex_ti]  <= 1'b1;
                btb_tag[ex_ti]    <= ex_tag;
                btb_target[ex_ti] <= act_tgt;
                btb_jal[ex_ti]    <= is_jal;
            end
        end
    end

    // Registered redirect: pulses for one unstalled cycle after a mispredict
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_o  <= 1'b0;
            addr_o      <= '0;
            pcmux_sel_o <= pc_plus4;
        end else if (!stall_i) begin
            if (train && mispred) begin
                redirect_o  <= 1'b1;
                addr_o      <= act_taken ? act_tgt : (ex_pc_i + FOUR);
                pcmux_sel_o <= is_jalr ? alu_mod2 : (act_taken ? alu_out : pc_plus4);
            end else begin
                redirect_o  <= 1'b0;
                pcmux_sel_o <= pc_plus4;
            end
        end
    end

    // Performance counters for resolved and mispredicted control flow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_o     <= '0;
            mispredict_cnt_o <= '0;
        end else if (train) begin
            branch_cnt_o     <= branch_cnt_o + 32'd1;
            mispredict_cnt_o <= mispredict_cnt_o + {31'b0, mispred};
        end
    end

endmodule
